// File: rtl/led_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | led_pkg: shared types and constants for the WS2812B frame path.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package led_pkg;

    localparam int GRB_W            = 24;
    localparam int NLEDS_W          = 4;
    localparam int BITS_PER_LED     = 24;
    localparam int ID_W             = 3;
    localparam int DEF_LATCH_CLKS   = 28100;
    localparam int DEF_TIMEOUT_CLKS = 400000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIP  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_LATCH = 3'd4
    } sched_state_e;

    function automatic logic nleds_ok(input logic [NLEDS_W-1:0] nleds, input int max_leds);
        return (nleds != '0) && (int'(nleds) <= max_leds);
    endfunction

    function automatic int frame_bits(input logic [NLEDS_W-1:0] nleds);
        return int'(nleds) * BITS_PER_LED;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_frame_scheduler_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arbiter: combinational round-robin pick of the first request  |
// | at or after ptr_i (mod N_REQ). Rev 1.0                           |
// +------------------------------------------------------------------+
module rr_arbiter
    import led_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  idx_o,
    output logic             valid_o
);

    always_comb begin
        int cand;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(ptr_i) + k) % N_REQ;
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = ID_W'(cand);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_frame_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | led_frame_scheduler: round-robin sharing of the WS2812B GRB path |
// | with ship/frame-done handshake, timeout and latch gap. Rev 1.0   |
// +------------------------------------------------------------------+
module led_frame_scheduler
    import led_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int MAX_LEDS     = 10,
    parameter int LATCH_CLKS   = DEF_LATCH_CLKS,
    parameter int TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [GRB_W*N_REQ-1:0]   req_grb,
    input  logic [NLEDS_W*N_REQ-1:0] req_nleds,
    output logic [N_REQ-1:0]         ack,
    output logic [ID_W-1:0]          grant_id,
    output logic                     ship,
    output logic [GRB_W-1:0]         ship_grb,
    output logic [NLEDS_W-1:0]       ship_nleds,
    input  logic                     frame_done,
    output logic                     busy,
    output logic                     err_timeout,
    output logic                     err_badlen
);

    localparam int LAT_W = $clog2(LATCH_CLKS);
    localparam int TMO_W = $clog2(TIMEOUT_CLKS);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CLKS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);

    sched_state_e       state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    win_q, win_d;
    logic [N_REQ-1:0]   win_oh_q, win_oh_d;
    logic [ID_W-1:0]    grant_q, grant_d;
    logic [N_REQ-1:0]   grant_oh_q, grant_oh_d;
    logic [GRB_W-1:0]   grb_q, grb_d;
    logic [NLEDS_W-1:0] nleds_q, nleds_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               err_tmo_q, err_tmo_d;
    logic               err_bad_q, err_bad_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;

    logic [N_REQ-1:0]   arb_gnt;
    logic [ID_W-1:0]    arb_idx;
    logic               arb_valid;
    logic [GRB_W-1:0]   sel_grb;
    logic [NLEDS_W-1:0] sel_nleds;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
        return (id == ID_W'(N_REQ - 1)) ? '0 : id + ID_W'(1);
    endfunction

    always_comb begin
        sel_grb   = '0;
        sel_nleds = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_q == ID_W'(i)) begin
                sel_grb   = req_grb[i*GRB_W +: GRB_W];
                sel_nleds = req_nleds[i*NLEDS_W +: NLEDS_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        win_d      = win_q;
        win_oh_d   = win_oh_q;
        grant_d    = grant_q;
        grant_oh_d = grant_oh_q;
        grb_d      = grb_q;
        nleds_d    = nleds_q;
        ack_d      = '0;
        err_tmo_d  = err_tmo_q;
        err_bad_d  = err_bad_q;
        lat_cnt_d  = lat_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    win_d    = arb_idx;
                    win_oh_d = arb_gnt;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                grant_d    = win_q;
                grant_oh_d = win_oh_q;
                grb_d      = sel_grb;
                nleds_d    = sel_nleds;
                if (nleds_ok(sel_nleds, MAX_LEDS)) begin
                    state_d = ST_SHIP;
                end else begin
                    // Rejected grants still rotate the pointer so a stuck bad requester cannot starve others.
                    err_bad_d = 1'b1;
                    ack_d     = win_oh_q;
                    ptr_d     = next_ptr(win_q);
                    lat_cnt_d = '0;
                    state_d   = ST_LATCH;
                end
            end
            ST_SHIP: begin
                tmo_cnt_d = '0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (frame_done) begin
                    ack_d     = grant_oh_q;
                    ptr_d     = next_ptr(grant_q);
                    lat_cnt_d = '0;
                    state_d   = ST_LATCH;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    err_tmo_d = 1'b1;
                    ack_d     = grant_oh_q;
                    ptr_d     = next_ptr(grant_q);
                    lat_cnt_d = '0;
                    state_d   = ST_LATCH;
                end else if (tmo_cnt_q != '1) begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            ST_LATCH: begin
                if (lat_cnt_q == LAT_LAST) begin
                    state_d = ST_IDLE;
                end else if (lat_cnt_q != '1) begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            win_q      <= '0;
            win_oh_q   <= '0;
            grant_q    <= '0;
            grant_oh_q <= '0;
            grb_q      <= '0;
            nleds_q    <= '0;
            ack_q      <= '0;
            err_tmo_q  <= 1'b0;
            err_bad_q  <= 1'b0;
            lat_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            win_oh_q   <= win_oh_d;
            grant_q    <= grant_d;
            grant_oh_q <= grant_oh_d;
            grb_q      <= grb_d;
            nleds_q    <= nleds_d;
            ack_q      <= ack_d;
            err_tmo_q  <= err_tmo_d;
            err_bad_q  <= err_bad_d;
            lat_cnt_q  <= lat_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    assign ack         = ack_q;
    assign grant_id    = grant_q;
    assign ship        = (state_q == ST_SHIP);
    assign ship_grb    = grb_q;
    assign ship_nleds  = nleds_q;
    assign busy        = (state_q != ST_IDLE);
    assign err_timeout = err_tmo_q;
    assign err_badlen  = err_bad_q;

endmodule
`default_nettype wire

// File: tb/tb_led_frame_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_led_frame_scheduler: directed table-driven bench for the      |
// | frame scheduler with short latch/timeout windows. Rev 1.0        |
// +------------------------------------------------------------------+
module tb_led_frame_scheduler;

    localparam int N   = 4;
    localparam int MAXL = 10;
    localparam int L   = 16;
    localparam int T   = 200;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [3:0]    req = '0;
    logic [95:0]   req_grb = '0;
    logic [15:0]   req_nleds = '0;
    logic [3:0]    ack;
    logic [2:0]    grant_id;
    logic          ship;
    logic [23:0]   ship_grb;
    logic [3:0]    ship_nleds;
    logic          frame_done = 1'b0;
    logic          busy;
    logic          err_timeout;
    logic          err_badlen;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_done = 0;
    string tag = "";

    led_frame_scheduler #(
        .N_REQ        (N),
        .MAX_LEDS     (MAXL),
        .LATCH_CLKS   (L),
        .TIMEOUT_CLKS (T)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_grb     (req_grb),
        .req_nleds   (req_nleds),
        .ack         (ack),
        .grant_id    (grant_id),
        .ship        (ship),
        .ship_grb    (ship_grb),
        .ship_nleds  (ship_nleds),
        .frame_done  (frame_done),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_badlen  (err_badlen)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  rq;
        logic [3:0]  rq_after;
        logic [95:0] grb;
        logic [15:0] nleds;
        logic [2:0]  exp_id;
        logic [23:0] exp_grb;
        logic [3:0]  exp_nleds;
        bit          exp_ship;
        int          dly;        // clocks from ship to frame_done; -1 = never
        bit          exp_bad;
        bit          exp_tmo;
        bit          chk_gap;
        bit          stale;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(logic [3:0] rq, logic [3:0] ra, logic [95:0] g, logic [15:0] n,
                                logic [2:0] id, logic [23:0] eg, logic [3:0] en, bit sh, int dly,
                                bit eb, bit et, bit gap, bit st);
        vec_t v;
        v.rq = rq; v.rq_after = ra; v.grb = g; v.nleds = n;
        v.exp_id = id; v.exp_grb = eg; v.exp_nleds = en; v.exp_ship = sh; v.dly = dly;
        v.exp_bad = eb; v.exp_tmo = et; v.chk_gap = gap; v.stale = st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s/%s actual=0x%0h expected=0x%0h", tag, name, act, exp);
        end
    endtask

    // Entered at a negedge with the DUT in IDLE; returns at the next IDLE negedge.
    task automatic apply(input vec_t v);
        int c;
        bit seen;
        req = v.rq; req_grb = v.grb; req_nleds = v.nleds;
        chk("idle", 32'(busy), 32'd0);
        @(negedge clk);
        chk("load_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        if (v.exp_ship) begin
            chk("ship", 32'(ship), 32'd1);
            chk("grant_id", 32'(grant_id), 32'(v.exp_id));
            chk("ship_grb", 32'(ship_grb), 32'(v.exp_grb));
            chk("ship_nleds", 32'(ship_nleds), 32'(v.exp_nleds));
            if (v.chk_gap) chk("ship_gap", 32'(cyc - last_done), 32'(L + 3));
            @(negedge clk);
            chk("ship_pulse", 32'(ship), 32'd0);
            if (v.dly > 0) begin
                repeat (v.dly - 1) @(negedge clk);
                frame_done = 1'b1;
                last_done = cyc;
                @(negedge clk);
                frame_done = 1'b0;
            end else begin
                c = 1;
                while (ack == '0 && c < T + 10) begin
                    @(negedge clk);
                    c++;
                end
                chk("tmo_latency", 32'(c), 32'(T + 1));
            end
        end else begin
            chk("no_ship", 32'(ship), 32'd0);
            chk("grant_id", 32'(grant_id), 32'(v.exp_id));
        end
        chk("ack", 32'(ack), 32'(4'b0001 << v.exp_id));
        chk("err_badlen", 32'(err_badlen), 32'(v.exp_bad));
        chk("err_timeout", 32'(err_timeout), 32'(v.exp_tmo));
        req = v.rq_after;
        @(negedge clk);
        chk("ack_pulse", 32'(ack), 32'd0);
        c = 1;
        seen = 1'b0;
        while (busy && c < L + 10) begin
            if (v.stale && c == 2) frame_done = 1'b1;
            @(negedge clk);
            frame_done = 1'b0;
            if (ack != '0 || ship) seen = 1'b1;
            c++;
        end
        chk("latch_len", 32'(c), 32'(L));
        chk("latch_quiet", 32'(seen), 32'd0);
    endtask

    initial begin
        int k;
        logic [95:0] g_rr;
        g_rr = {24'hAABBCC, 24'h778899, 24'h445566, 24'h112233};
        //           rq       after    grb                        nleds     id  exp_grb      n   sh dly  bad tmo gap stale
        vecs[0]  = mk(4'b1111, 4'b1111, g_rr,                      16'hA751, 0, 24'h112233, 1,  1, 5,   0, 0, 0, 0);
        vecs[1]  = mk(4'b1111, 4'b1111, g_rr,                      16'hA751, 1, 24'h445566, 5,  1, 10,  0, 0, 1, 0);
        vecs[2]  = mk(4'b1111, 4'b1111, g_rr,                      16'hA751, 2, 24'h778899, 7,  1, 3,   0, 0, 1, 0);
        vecs[3]  = mk(4'b1111, 4'b1111, g_rr,                      16'hA751, 3, 24'hAABBCC, 10, 1, 20,  0, 0, 1, 0);
        vecs[4]  = mk(4'b1111, 4'b0000, g_rr,                      16'hA751, 0, 24'h112233, 1,  1, 8,   0, 0, 1, 0);
        vecs[5]  = mk(4'b0001, 4'b0000, {72'd0, 24'h00FF00},       16'h0003, 0, 24'h00FF00, 3,  1, 72,  0, 0, 0, 0);
        vecs[6]  = mk(4'b0100, 4'b0000, g_rr,                      16'h0000, 2, 24'h0,      0,  0, 0,   1, 0, 0, 0);
        vecs[7]  = mk(4'b1000, 4'b0000, g_rr,                      16'hB000, 3, 24'h0,      0,  0, 0,   1, 0, 0, 0);
        vecs[8]  = mk(4'b0010, 4'b0000, {48'd0, 24'h123456, 24'd0}, 16'h0020, 1, 24'h123456, 2,  1, -1,  1, 1, 0, 0);
        vecs[9]  = mk(4'b0101, 4'b0000, {24'd0, 24'hC0FFEE, 24'd0, 24'h010203}, 16'h0403, 2, 24'hC0FFEE, 4, 1, 4, 1, 1, 0, 0);
        vecs[10] = mk(4'b0011, 4'b0000, {48'd0, 24'h777777, 24'h0A0B0C}, 16'h0069, 0, 24'h0A0B0C, 9, 1, 6, 1, 1, 0, 0);
        vecs[11] = mk(4'b0001, 4'b0000, {72'd0, 24'hFFFFFF},       16'h0002, 0, 24'hFFFFFF, 2,  1, 6,   0, 0, 0, 0);
        vecs[12] = mk(4'b0001, 4'b0000, {72'd0, 24'h5A5A5A},       16'h000A, 0, 24'h5A5A5A, 10, 1, T,   0, 0, 0, 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        tag = "reset";
        chk("busy", 32'(busy), 32'd0);
        chk("ship", 32'(ship), 32'd0);
        chk("ack", 32'(ack), 32'd0);
        chk("outs", {grant_id, ship_grb, ship_nleds, err_timeout}, 32'd0);
        chk("err_badlen", 32'(err_badlen), 32'd0);
        reset = 1'b1;

        for (k = 0; k <= 10; k++) begin
            tag = $sformatf("v%0d", k);
            apply(vecs[k]);
        end

        // Reset asserted while a frame is in flight.
        tag = "rst_wait";
        req = 4'b0001; req_grb = {72'd0, 24'h0F0F0F}; req_nleds = 16'h0005;
        @(negedge clk);
        @(negedge clk);
        chk("ship", 32'(ship), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        req = '0;
        @(negedge clk);
        chk("busy", 32'(busy), 32'd0);
        chk("ship_grb", 32'(ship_grb), 32'd0);
        chk("ship_nleds", 32'(ship_nleds), 32'd0);
        chk("grant_id", 32'(grant_id), 32'd0);
        chk("ack", 32'(ack), 32'd0);
        chk("errs", {30'd0, err_timeout, err_badlen}, 32'd0);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("quiet", {27'd0, ack, busy}, 32'd0);
        end

        for (k = 11; k <= 12; k++) begin
            tag = $sformatf("v%0d", k);
            apply(vecs[k]);
        end

        // A stray frame_done in IDLE must not start anything.
        tag = "stale_idle";
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
        chk("ack", 32'(ack), 32'd0);
        @(negedge clk);
        chk("busy_ship", {30'd0, busy, ship}, 32'd0);
        chk("err_timeout", 32'(err_timeout), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
